// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state enum (IDLE, MERGE, DONE)
//   - default data memory depth (MEM_WORDS_DEFAULT)
//   - funct3_legal(): legality of a funct3 for a load or a store
package lsu_pkg;

    localparam int MEM_WORDS_DEFAULT = 1024;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        DONE  = 2'd2
    } lsu_state_e;

    // Stores only come in signed encodings; the unsigned ones are load-only.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response bundle between execute and the load/store unit.
//   req_valid/req_ready   : accept handshake (accept = valid && ready)
//   req_write             : 1 = store, 0 = load
//   req_funct3            : RV32I load/store funct3
//   req_addr, req_wdata   : byte address, right-aligned store data
//   resp_valid            : one-cycle completion pulse
//   resp_rdata, resp_error: extended load data, fault flag
// modport master = requester (execute), modport slave = load_store_unit.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane handling for the load/store unit.
//   funct3        : in, RV32I load/store funct3
//   addr_low      : in, req_addr[1:0]
//   mem_read_data : in, word read from data memory
//   req_wdata     : in, right-aligned store data
//   load_value    : out, selected byte/halfword/word, sign- or zero-extended
//   store_word    : out, read word with the addressed lane(s) replaced
// Halfword lanes use addr_low[1] only and words ignore addr_low, so a
// misaligned request that is not trapped silently rounds down.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_low,
    input  logic [31:0] mem_read_data,
    input  logic [31:0] req_wdata,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        load_byte  = mem_read_data[7:0];
        load_half  = addr_low[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_value = mem_read_data;
        case (addr_low)
            2'd1:    load_byte = mem_read_data[15:8];
            2'd2:    load_byte = mem_read_data[23:16];
            2'd3:    load_byte = mem_read_data[31:24];
            default: load_byte = mem_read_data[7:0];
        endcase
        case (funct3)
            F3_B:    load_value = {{24{load_byte[7]}}, load_byte};
            F3_BU:   load_value = {24'h000000, load_byte};
            F3_H:    load_value = {{16{load_half[15]}}, load_half};
            F3_HU:   load_value = {16'h0000, load_half};
            default: load_value = mem_read_data;
        endcase
    end

    // Each byte lane of the merged word either keeps the memory byte or takes
    // the matching byte of the store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_src;

            assign lane_hit = (funct3 == F3_B) ? (addr_low == 2'(gi)) :
                              (funct3 == F3_H) ? (addr_low[1] == 1'(gi / 2)) :
                              1'b1;
            assign lane_src = (funct3 == F3_B) ? req_wdata[7:0] :
                              (funct3 == F3_H) ? req_wdata[(gi % 2) * 8 +: 8] :
                              req_wdata[gi * 8 +: 8];
            assign store_word[gi * 8 +: 8] = lane_hit ? lane_src : mem_read_data[gi * 8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage translating RV32I byte-addressed
// LB/LH/LW/LBU/LHU/SB/SH/SW into accesses on a word-wide data memory.
//   clock, reset     : clock, asynchronous active-high reset
//   bus (lsu_if)     : request/response handshake (slave side)
//   mem_read_enable  : out, read strobe to data_memory
//   mem_write_enable : out, write strobe to data_memory
//   mem_address      : out, word index (req_addr >> 2)
//   mem_write_data   : out, word to write
//   mem_read_data    : in, combinational read word from data_memory
// Loads and SW complete one cycle after accept; SB/SH read the word in the
// accept cycle and write the merged word in MERGE, completing one cycle later.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// requests fault instead of rounding the address down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    lsu_if.slave        bus,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // 33 bits so that the limit itself is representable for any depth.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    lsu_state_e  state_reg, state_next;
    logic [31:0] resp_rdata_reg, resp_rdata_next;
    logic        resp_error_reg, resp_error_next;
    logic [31:0] merge_word_reg, merge_word_next;
    logic [31:0] merge_index_reg, merge_index_next;

    logic        accept;
    logic        req_legal;
    logic        req_in_range;
    logic        req_misaligned;
    logic        req_error;
    logic [31:0] word_index;
    logic [31:0] load_value;
    logic [31:0] store_word;

    assign word_index   = {2'b00, bus.req_addr[31:2]};
    assign accept       = bus.req_valid && (state_reg == IDLE);
    assign req_legal    = funct3_legal(bus.req_write, bus.req_funct3);
    assign req_in_range = {1'b0, bus.req_addr} < ADDR_LIMIT;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misaligned =
        (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0]) ||
        ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    assign req_error = !req_legal || !req_in_range || req_misaligned;

    lsu_align u_align (
        .funct3        (bus.req_funct3),
        .addr_low      (bus.req_addr[1:0]),
        .mem_read_data (mem_read_data),
        .req_wdata     (bus.req_wdata),
        .load_value    (load_value),
        .store_word    (store_word)
    );

    // Async reset clears the pending merge too, so a reset during MERGE
    // drops the write rather than completing it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            resp_rdata_reg  <= 32'h0;
            resp_error_reg  <= 1'b0;
            merge_word_reg  <= 32'h0;
            merge_index_reg <= 32'h0;
        end else begin
            state_reg       <= state_next;
            resp_rdata_reg  <= resp_rdata_next;
            resp_error_reg  <= resp_error_next;
            merge_word_reg  <= merge_word_next;
            merge_index_reg <= merge_index_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        resp_rdata_next  = resp_rdata_reg;
        resp_error_next  = resp_error_reg;
        merge_word_next  = merge_word_reg;
        merge_index_next = merge_index_reg;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next      = DONE;
                    resp_rdata_next = 32'h0;
                    resp_error_next = req_error;
                    if (!req_error) begin
                        mem_address = word_index;
                        if (!bus.req_write) begin
                            mem_read_enable = 1'b1;
                            resp_rdata_next = load_value;
                        end else if (bus.req_funct3 == F3_W) begin
                            mem_write_enable = 1'b1;
                            mem_write_data   = bus.req_wdata;
                        end else begin
                            mem_read_enable  = 1'b1;
                            merge_word_next  = store_word;
                            merge_index_next = word_index;
                            state_next       = MERGE;
                        end
                    end
                end
            end
            MERGE: begin
                mem_write_enable = 1'b1;
                mem_address      = merge_index_reg;
                mem_write_data   = merge_word_reg;
                state_next       = DONE;
            end
            DONE: begin
                // Response fields read as zero outside the DONE pulse.
                state_next      = IDLE;
                resp_rdata_next = 32'h0;
                resp_error_next = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.resp_valid = (state_reg == DONE);
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_error = resp_error_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a
// word-wide memory model behind it and a response scoreboard.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 1024;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    lsu_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    // ---------------- data memory and reference model ----------------
    logic [31:0] tb_mem [0:MEM_WORDS-1];
    logic [31:0] model_mem [0:MEM_WORDS-1];
    logic        mem_init = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5C30000 ^ (32'(i) * 32'h00010107);
    endfunction

    assign mem_read_data = tb_mem[mem_address[9:0]];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] <= init_word(i);
        end else if (mem_write_enable) begin
            tb_mem[mem_address[9:0]] <= mem_write_data;
        end
    end

    // ---------------- bookkeeping ----------------
    int          n_asserts = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          accepts = 0;
    int          writes = 0;
    int          resps = 0;
    int          last_acc_cycle = 0;
    int          last_wr_cycle = 0;
    int          last_resp_cycle = 0;
    logic [31:0] last_wr_data = 32'h0;
    logic [31:0] last_wr_addr = 32'h0;
    logic        acc_re = 1'b0;
    logic        acc_we = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    string       step = "reset";
    exp_t        exp_q[$];
    exp_t        e_resp;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s/%s observed=%h expected=%h", step, tag, observed, expected);
        end
    endtask

    always @(posedge clock) begin
        if (!reset && bus.req_valid && bus.req_ready) begin
            accepts++;
            last_acc_cycle = cycle;
        end
        if (mem_write_enable) begin
            writes++;
            last_wr_cycle = cycle;
            last_wr_addr  = mem_address;
            last_wr_data  = mem_write_data;
        end
        cycle++;
    end

    always @(negedge clock) begin
        if (bus.resp_valid) begin
            resps++;
            last_resp_cycle = cycle;
            check("resp_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e_resp = exp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, e_resp.rdata);
                check("resp_error", 32'(bus.resp_error), 32'(e_resp.error));
            end
        end
    end

    // Reference behaviour of one request; applies stores to model_mem.
    function automatic exp_t model_access(input logic wr, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        r;
        logic        legal;
        logic        bad_align;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] b;
        logic [31:0] h;
        int          idx;
        int          sh;
        r.rdata = 32'h0;
        r.error = 1'b0;
        if (wr) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
        bad_align = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (((f3 == 3'b001) || (f3 == 3'b101)) && addr[0]) bad_align = 1'b1;
        if ((f3 == 3'b010) && (addr[1:0] != 2'b00)) bad_align = 1'b1;
`endif
        if (!legal || (addr >= 32'(4 * MEM_WORDS)) || bad_align) begin
            r.error = 1'b1;
            return r;
        end
        idx  = int'(addr[11:2]);
        word = model_mem[idx];
        b    = word >> (8 * int'(addr[1:0]));
        h    = word >> (addr[1] ? 16 : 0);
        if (!wr) begin
            case (f3)
                3'b000:  r.rdata = {{24{b[7]}}, b[7:0]};
                3'b001:  r.rdata = {{16{h[15]}}, h[15:0]};
                3'b100:  r.rdata = {24'h0, b[7:0]};
                3'b101:  r.rdata = {16'h0, h[15:0]};
                default: r.rdata = word;
            endcase
        end else begin
            case (f3)
                3'b000: begin
                    sh   = 8 * int'(addr[1:0]);
                    mask = 32'hFF << sh;
                    model_mem[idx] = (word & ~mask) | ((wdata & 32'hFF) << sh);
                end
                3'b001: begin
                    sh   = addr[1] ? 16 : 0;
                    mask = 32'hFFFF << sh;
                    model_mem[idx] = (word & ~mask) | ((wdata & 32'hFFFF) << sh);
                end
                default: model_mem[idx] = wdata;
            endcase
        end
        return r;
    endfunction

    // Drives a request and holds it until accepted; req_valid stays high on
    // return so consecutive calls form a back-to-back stream.
    task automatic issue(input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int k;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        k = 0;
        forever begin
            @(negedge clock);
            if (bus.req_ready) break;
            k++;
            if (k > 20) begin
                check("accept_timeout", 32'(k), 32'd0);
                bus.req_valid = 1'b0;
                return;
            end
        end
        acc_re   = mem_read_enable;
        acc_we   = mem_write_enable;
        acc_addr = mem_address;
        exp_q.push_back(model_access(wr, f3, addr, wdata));
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clock);
            k++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int a0;
        int c1;
        int c2;
        int c3;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = init_word(i);
        mem_init = 1'b1;

        #1;
        reset = 1'b1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_error", 32'(bus.resp_error), 32'd0);
        check("rst_mem_re", 32'(mem_read_enable), 32'd0);
        check("rst_mem_we", 32'(mem_write_enable), 32'd0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);

        @(posedge clock);
        #1;
        mem_init = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        step = "sw";
        w0 = writes;
        issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        idle();
        drain();
        check("acc_we", 32'(acc_we), 32'd1);
        check("acc_addr", acc_addr, 32'd4);
        check("writes", 32'(writes - w0), 32'd1);
        check("wr_addr", last_wr_addr, 32'd4);
        check("wr_data", last_wr_data, 32'hDEADBEEF);
        check("wr_cycle", 32'(last_wr_cycle - last_acc_cycle), 32'd0);
        check("latency", 32'(last_resp_cycle - last_acc_cycle), 32'd1);

        step = "lw";
        issue(1'b0, F3_W, 32'h10, 32'h0);
        idle();
        drain();
        check("acc_re", 32'(acc_re), 32'd1);
        check("acc_addr", acc_addr, 32'd4);
        check("model_word4", model_mem[4], 32'hDEADBEEF);

        step = "lb_lbu";
        issue(1'b0, F3_B, 32'h13, 32'h0);
        issue(1'b0, F3_BU, 32'h13, 32'h0);
        idle();
        drain();

        step = "sb";
        w0 = writes;
        issue(1'b1, F3_B, 32'h11, 32'h55);
        idle();
        drain();
        check("acc_re", 32'(acc_re), 32'd1);
        check("writes", 32'(writes - w0), 32'd1);
        check("wr_data", last_wr_data, 32'hDEAD55EF);
        check("wr_cycle", 32'(last_wr_cycle - last_acc_cycle), 32'd1);
        check("latency", 32'(last_resp_cycle - last_acc_cycle), 32'd2);

        step = "sh";
        issue(1'b1, F3_H, 32'h12, 32'h1234);
        idle();
        drain();
        check("wr_data", last_wr_data, 32'h123455EF);
        check("wr_addr", last_wr_addr, 32'd4);

        step = "half_loads";
        issue(1'b0, F3_H, 32'h12, 32'h0);
        issue(1'b0, F3_HU, 32'h10, 32'h0);
        issue(1'b0, F3_B, 32'h10, 32'h0);
        issue(1'b0, F3_H, 32'h22, 32'h0);
        issue(1'b0, F3_HU, 32'h22, 32'h0);
        idle();
        drain();

        step = "lw_misaligned";
        issue(1'b0, F3_W, 32'h11, 32'h0);
        idle();
        drain();
`ifdef LSU_MISALIGN_TRAP_EN
        check("acc_re", 32'(acc_re), 32'd0);
        check("acc_we", 32'(acc_we), 32'd0);
`else
        check("acc_re", 32'(acc_re), 32'd1);
        check("acc_addr", acc_addr, 32'd4);
`endif

        step = "lh_odd";
        issue(1'b0, F3_H, 32'h13, 32'h0);
        idle();
        drain();

        step = "illegal";
        w0 = writes;
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        idle();
        drain();
        check("acc_re", 32'(acc_re), 32'd0);
        issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
        idle();
        drain();
        check("acc_we", 32'(acc_we), 32'd0);
        check("writes", 32'(writes - w0), 32'd0);

        step = "range";
        w0 = writes;
        issue(1'b1, F3_W, 32'h1000, 32'h0BADF00D);
        idle();
        drain();
        check("acc_we", 32'(acc_we), 32'd0);
        check("writes", 32'(writes - w0), 32'd0);
        check("latency", 32'(last_resp_cycle - last_acc_cycle), 32'd1);
        issue(1'b0, F3_W, 32'hFFFFF010, 32'h0);
        issue(1'b0, F3_W, 32'hFFC, 32'h0);
        idle();
        drain();

        step = "backpressure";
        a0 = accepts;
        w0 = writes;
        issue(1'b0, F3_W, 32'h20, 32'h0);
        c1 = last_acc_cycle;
        issue(1'b1, F3_B, 32'h21, 32'hAA);
        c2 = last_acc_cycle;
        issue(1'b0, F3_W, 32'h20, 32'h0);
        c3 = last_acc_cycle;
        idle();
        drain();
        check("accepts", 32'(accepts - a0), 32'd3);
        check("writes", 32'(writes - w0), 32'd1);
        check("interval_lw", 32'(c2 - c1), 32'd2);
        check("interval_sb", 32'(c3 - c2), 32'd3);

        step = "reset_in_merge";
        w0 = writes;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'h77;
        @(negedge clock);
        check("ready_before", 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("merge_we", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("mem_we", 32'(mem_write_enable), 32'd0);
        check("mem_addr", mem_address, 32'h0);
        check("mem_wdata", mem_write_data, 32'h0);
        check("req_ready", 32'(bus.req_ready), 32'd1);
        check("resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("writes", 32'(writes - w0), 32'd0);
        issue(1'b0, F3_W, 32'h40, 32'h0);
        idle();
        drain();
        check("word16_intact", model_mem[16], init_word(16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
